demo_logic: RTL and testbench



---
 rtl/demo_logic.sv | 75 +++++++
 tb/tb_demo_logic.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demo_logic.sv
// Two-input clocked logic cell with input synchronizers, selectable
// boolean function, registered result and saturating toggle counter.
module demo_logic #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic [2:0]       op,
  input  logic             cnt_clr,
  output logic             c,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic                   a_s;
  logic                   b_s;
  logic                   f;
  logic                   c_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b};
    end
  end

  assign a_s = a_sync[SYNC_STAGES-1];
  assign b_s = b_sync[SYNC_STAGES-1];

  always_comb begin
    f = 1'b0;
    case (op)
      3'd0: f = a_s & b_s;
      3'd1: f = a_s | b_s;
      3'd2: f = a_s ^ b_s;
      3'd3: f = ~(a_s & b_s);
      3'd4: f = ~(a_s | b_s);
      3'd5: f = ~(a_s ^ b_s);
      3'd6: f = a_s;
      3'd7: f = b_s;
      default: f = 1'b0;
    endcase
  end

  // op is quasi-static, so it feeds the result flop directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c   <= 1'b0;
      c_d <= 1'b0;
    end else begin
      c   <= f;
      c_d <= c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else if (cnt_clr) begin
      toggle_cnt <= '0;
    end else if ((c != c_d) && (toggle_cnt != CNT_MAX)) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demo_logic.sv
// Directed bench for demo_logic: default 8-bit counter instance plus a
// 2-bit counter instance sharing the same stimulus for saturation.
module tb_demo_logic;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic [2:0] op;
  logic       cnt_clr;
  logic       c0;
  logic       c1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int n_chk;
  int n_bad;

  // truth tables indexed by {a,b}
  logic [3:0] tt [8];

  demo_logic #(.SYNC_STAGES(2), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .cnt_clr(cnt_clr), .c(c0), .toggle_cnt(cnt0)
  );

  demo_logic #(.SYNC_STAGES(2), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .cnt_clr(cnt_clr), .c(c1), .toggle_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    tt[0] = 4'b1000;
    tt[1] = 4'b1110;
    tt[2] = 4'b0110;
    tt[3] = 4'b0111;
    tt[4] = 4'b0001;
    tt[5] = 4'b1001;
    tt[6] = 4'b1100;
    tt[7] = 4'b1010;

    rst_n   = 1'b0;
    a       = 1'b1;
    b       = 1'b1;
    op      = 3'd0;
    cnt_clr = 1'b0;

    // reset hold with a=b=1
    #20;
    chk("rst_c_20", c0, 0);
    chk("rst_cnt_20", cnt0, 0);
    #25;
    chk("rst_c_45", c0, 0);
    chk("rst_cnt_45", cnt0, 0);
    #1;
    rst_n = 1'b1;
    tick(2);
    chk("rel_c_e2", c0, 0);
    tick(1);
    chk("rel_c_e3", c0, 1);
    chk("rel_cnt_e3", cnt0, 0);
    tick(1);
    chk("rel_cnt_e4", cnt0, 1);

    // settle low, clear counter
    a = 1'b0;
    b = 1'b0;
    tick(10);
    chk("low_c", c0, 0);
    chk("low_cnt", cnt0, 2);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clr_cnt", cnt0, 0);

    // AND sweep
    a = 1'b0; b = 1'b0; tick(10);
    chk("and_00", c0, 0);
    a = 1'b1; b = 1'b0; tick(10);
    chk("and_10", c0, 0);
    a = 1'b0; b = 1'b1; tick(10);
    chk("and_01", c0, 0);
    a = 1'b1; b = 1'b1;
    tick(2);
    chk("and_11_e2", c0, 0);
    tick(1);
    chk("and_11_e3", c0, 1);
    tick(7);
    chk("and_cnt", cnt0, 1);

    // function sweep over all ops and operand pairs
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 4; i++) begin
        logic [1:0] ab;
        logic [3:0] row;
        ab  = 2'(i);
        row = tt[o];
        op  = 3'(o);
        a   = ab[1];
        b   = ab[0];
        tick(4);
        chk($sformatf("fn_op%0d_ab%0d", o, i), c0, row[i]);
      end
    end

    // op change takes effect on the next edge
    op = 3'd0; a = 1'b1; b = 1'b0;
    tick(4);
    chk("opl_c0", c0, 0);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("opl_clr", cnt0, 0);
    op = 3'd1;
    tick(1);
    chk("opl_c1", c0, 1);
    chk("opl_cnt_e1", cnt0, 0);
    tick(1);
    chk("opl_cnt_e2", cnt0, 1);

    // saturation: c follows a with b=1
    op = 3'd0; b = 1'b1; a = 1'b1;
    tick(5);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("sat_clr0", cnt0, 0);
    chk("sat_clr1", cnt1, 0);
    for (int k = 0; k < 5; k++) begin
      a = ~a;
      tick(6);
    end
    chk("sat_c", c0, 0);
    chk("sat_cnt8", cnt0, 5);
    chk("sat_cnt2", cnt1, 3);

    // clear wins over a coincident toggle
    a = 1'b1;
    tick(3);
    chk("clrtg_c", c0, 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clrtg_cnt8", cnt0, 0);
    chk("clrtg_cnt2", cnt1, 0);
    tick(2);
    chk("clrtg_hold", cnt0, 0);

    // reach c=1, toggle_cnt=2
    a = 1'b0; tick(6);
    a = 1'b1; tick(6);
    chk("pre_c", c0, 1);
    chk("pre_cnt", cnt0, 2);

    // async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_c", c0, 0);
    chk("arst_cnt", cnt0, 0);
    chk("arst_cnt2", cnt1, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("arst_e1", c0, 0);
    tick(1);
    chk("arst_e2", c0, 0);
    tick(1);
    chk("arst_e3", c0, 1);
    chk("arst_cnt_e3", cnt0, 0);
    tick(1);
    chk("arst_cnt_e4", cnt0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
